dm_reg_responder: RTL

DM_REG_RESPONDER -- requirements
Module: dm_reg_responder

---
 rtl/dm_resp_pkg.sv | 13 +
 rtl/dm_resp_regfile.sv | 20 ++
 rtl/dm_reg_responder.sv | 85 ++++++++
 3 files changed

// File: rtl/dm_resp_pkg.sv
// dm_resp_pkg: opcodes, status codes, FSM states and address limit for dm_reg_responder
package dm_resp_pkg;
  localparam logic [7:0] OP_READ  = 8'h01;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_SET   = 8'h03;
  localparam logic [7:0] OP_CLR   = 8'h04;
  localparam logic [7:0] ST_OK        = 8'h00;
  localparam logic [7:0] ST_BAD_OP    = 8'h01;
  localparam logic [7:0] ST_BAD_ADDR  = 8'h02;
  localparam logic [7:0] ST_READ_ONLY = 8'h03;
  localparam logic [23:0] REG_ADDR_MAX = 24'h00003C;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;
endpackage

// File: rtl/dm_resp_regfile.sv
// dm_resp_regfile: 15 writable 32-bit registers plus a read-only ID register at index 15
module dm_resp_regfile #(
  parameter logic [31:0] ID_VALUE = 32'h0D3B_0001
) (
  input  logic        clk2,
  input  logic        rst_n_ck2,
  input  logic        i_we,
  input  logic [3:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_raddr,
  output logic [31:0] o_rdata,
  output logic [31:0] o_reg0
);
  logic [31:0] r_mem [0:14];
  always_ff @(posedge clk2 or negedge rst_n_ck2)
    if (!rst_n_ck2) for (int i = 0; i < 15; i++) r_mem[i] <= '0;
    else if (i_we && i_waddr != 4'd15) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = (i_raddr == 4'd15) ? ID_VALUE : r_mem[i_raddr];
  assign o_reg0  = r_mem[0];
endmodule

// File: rtl/dm_reg_responder.sv
// dm_reg_responder: single-outstanding register request/response engine with a
// fixed execute-stage delay in front of a 16-entry register file
module dm_reg_responder
  import dm_resp_pkg::*;
#(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] ID_VALUE    = 32'h0D3B_0001
) (
  input  logic        clk2,
  input  logic        rst_n_ck2,
  input  logic        req_vld_ck2,
  output logic        req_rdy_ck2,
  input  logic [23:0] req_addr_ck2,
  input  logic [31:0] req_data_ck2,
  input  logic [7:0]  req_op_ck2,
  output logic        resp_vld_ck2,
  input  logic        resp_rdy_ck2,
  output logic [23:0] resp_addr_ck2,
  output logic [31:0] resp_data_ck2,
  output logic [7:0]  resp_op_ck2,
  output logic [31:0] ctrl_reg_ck2
);
  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [23:0] r_addr;
  logic [31:0] r_data;
  logic [7:0]  r_op;
  logic [31:0] r_resp_data;
  logic [7:0]  r_resp_op;
  logic        w_fire, w_done, w_bad_addr, w_known, w_ro, w_we;
  logic [7:0]  w_status;
  logic [31:0] w_rd, w_new;
  assign w_fire     = req_vld_ck2 && r_state == S_IDLE;
  assign w_done     = r_state == S_EXEC && r_cnt == 4'd0;
  assign w_bad_addr = (|r_addr[1:0]) || r_addr > REG_ADDR_MAX;
  assign w_known    = r_op == OP_READ || r_op == OP_WRITE || r_op == OP_SET || r_op == OP_CLR;
  assign w_ro       = r_addr[5:2] == 4'd15 && r_op != OP_READ;
  assign w_status   = w_bad_addr ? ST_BAD_ADDR : !w_known ? ST_BAD_OP : w_ro ? ST_READ_ONLY : ST_OK;
  assign w_new      = r_op == OP_WRITE ? r_data :
                      r_op == OP_SET   ? (w_rd | r_data) :
                      r_op == OP_CLR   ? (w_rd & ~r_data) : w_rd;
  // Error statuses never reach the write port, so the register file stays untouched
  assign w_we       = w_done && w_status == ST_OK && r_op != OP_READ;
  dm_resp_regfile #(.ID_VALUE(ID_VALUE)) u_regfile (
    .clk2      (clk2),
    .rst_n_ck2 (rst_n_ck2),
    .i_we      (w_we),
    .i_waddr   (r_addr[5:2]),
    .i_wdata   (w_new),
    .i_raddr   (r_addr[5:2]),
    .o_rdata   (w_rd),
    .o_reg0    (ctrl_reg_ck2)
  );
  always_ff @(posedge clk2 or negedge rst_n_ck2)
    if (!rst_n_ck2) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_op        <= '0;
      r_resp_data <= '0;
      r_resp_op   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_fire) begin
          r_state <= S_EXEC;
          r_cnt   <= 4'(WAIT_CYCLES);
          r_addr  <= req_addr_ck2;
          r_data  <= req_data_ck2;
          r_op    <= req_op_ck2;
        end
        S_EXEC: if (w_done) begin
          r_state     <= S_RESP;
          r_resp_op   <= w_status;
          r_resp_data <= (w_status == ST_OK) ? w_new : '0;
        end else r_cnt <= r_cnt - 4'd1;
        default: if (resp_rdy_ck2) r_state <= S_IDLE;
      endcase
    end
  assign req_rdy_ck2   = r_state == S_IDLE;
  assign resp_vld_ck2  = r_state == S_RESP;
  assign resp_addr_ck2 = r_addr;
  assign resp_data_ck2 = r_resp_data;
  assign resp_op_ck2   = r_resp_op;
endmodule
